relogio_bcd: RTL and testbench
==============================

# relogio_bcd

Time-of-day counter feeding the display path: counts HH:MM:SS in BCD from a 1 Hz tick derived internally from the system clock, and exposes six 4-bit BCD digits that drive one `bcd_para_7seg` decoder per display digit. It supports run/hold and a set mode that allows minutes and hours to be stepped manually. All digit outputs are guaranteed to stay in 0–9, with tens digits inside their modulo range, so a downstream decoder never shows its error glyph.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency. One seconds tick occurs every `CLK_HZ` enabled cycles. Minimum value is 2.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: 1 = counting; 0 = hold the digits and the prescaler count.
- `set_en` in 1: set mode. Seconds are forced to 00, the prescaler is cleared and ticks are suppressed.
- `inc_min` in 1: single-cycle pulse, honoured only while `set_en`=1.
- `inc_hour` in 1: single-cycle pulse, honoured only while `set_en`=1.
- `sec_u`, `sec_t`, `min_u`, `min_t`, `hr_u`, `hr_t` out 4 each: BCD digits, units and tens. All are registered.
- `pm` out 1: PM flag (see Configuration).
- `tick_1hz` out 1: high for one cycle when the seconds value advances.
- `day_wrap` out 1: high for one cycle on the midnight rollover.

## Operation
- Priority, highest first: `reset`, then `set_en`, then `run`.
- Prescaler `cnt` runs from 0 to `CLK_HZ`-1.
  - It advances only when `run`=1 and `set_en`=0.
  - When `cnt`=`CLK_HZ`-1 and the prescaler is enabled, the next edge sets `cnt` to 0 and increments seconds.
- Seconds increment and carry:
  - `sec_u` 9 to 0 carries into `sec_t`.
  - `sec_t` 5 to 0 (at :59) carries into the minutes, using the same 9/5 rule.
  - :59 on minutes carries into the hours.
  - Hours wrap 23 to 00 (24 h mode). Hour digit limits are: `hr_u` 0–9 when `hr_t`<2, and 0–3 when `hr_t`=2.
- Set mode (`set_en`=1):
  - Every edge loads `sec_t`=`sec_u`=0 and `cnt`=0.
  - `inc_min` increments the minutes modulo 60 with no carry into hours.
  - `inc_hour` increments the hours modulo 24 with no carry.
  - Both pulses in the same cycle: both apply independently.
  - Pulses received while `set_en`=0 are ignored.
- Leaving set mode: counting restarts from `cnt`=0, so the first tick comes `CLK_HZ` cycles after the first enabled cycle.
- Reset values: digits 00:00:00, `pm`=0, `tick_1hz`=0, `day_wrap`=0, `cnt`=0.
- Reset asserted mid-count or mid-set aborts everything and restores the reset values on that edge.

## Timing
- Latency: the new digit values, `tick_1hz` and `day_wrap` all appear on the edge after the terminal prescaler cycle, in the same cycle as each other.
- `tick_1hz` and `day_wrap` are never asserted in set mode or while `run`=0.
- `day_wrap` fires only on a counted rollover from 23:59:59 to 00:00:00, never on a manual `inc_hour` wrap.
- An `inc_*` pulse takes effect on the next edge; the digits are valid one cycle after the pulse.
- With `run`=0, `cnt` is frozen. Raising `run` again resumes from the frozen count, so there is no phase loss.

## Configuration
- `RELOGIO_FORMATO_12H_EN` defined:
  - Hours count 12, 01 … 11, with `pm` marking the half-day.
  - The 11 to 12 transition toggles `pm`. This applies both when counting and on `inc_hour`.
  - Reset value is 12:00:00, `pm`=0.
  - `day_wrap` fires on the counted transition 11:59:59 PM to 12:00:00 AM.
- `RELOGIO_FORMATO_12H_EN` not defined:
  - 24 h counting, 00–23.
  - `pm` is tied to 0.

## Structure
- Package `relogio_pkg`:
  - BCD digit width (4).
  - Digit limits (`SEG_T_MAX`=5, `HR_T_MAX`=2, `HR_U_MAX_24`=3).
  - Reset hour constants for both formats.
- Sub-module `divisor_tick`:
  - Parameter `CLK_HZ`.
  - Inputs `clk`, `reset`, `en`, `clr`.
  - Output: single-cycle terminal-count pulse.
- Digit chaining and set logic live in `relogio_bcd`.

## Test plan
All scenarios run with `CLK_HZ`=4.
- Reset, then `run`=1 for 4 cycles: outputs go from 00:00:00 to 00:00:01, with `tick_1hz` high for exactly 1 cycle.
- `set_en`=1, 23× `inc_hour`, 59× `inc_min`, `set_en`=0, then 59 ticks: 23:59:59. The next tick gives 00:00:00 with `day_wrap` and `tick_1hz` both high in that same cycle.
- Counting at 00:00:37, raise `set_en`: next edge shows 00:00:00. `inc_min` pulsed with `set_en`=0 leaves the minutes unchanged.
- Set mode at 00:59, `inc_min` and `inc_hour` in the same cycle: result 01:00:00, with no extra hour carry and `day_wrap`=0.
- `run`=0 after 2 prescaler cycles, hold for 10 cycles: digits unchanged. `run`=1: the tick arrives after 2 more cycles.
- Macro defined: 11:59:59 `pm`=0, then one tick: 12:00:00 `pm`=1. Reset mid-count restores 12:00:00 `pm`=0.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared BCD types, digit limits and reset hours for the relogio_bcd clock.
// Also holds the BCD increment helpers used by the digit chain.
package relogio_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Tens and units of one two-digit field (seconds, minutes or hours).
    typedef struct packed {
        bcd_t t;
        bcd_t u;
    } bcd2_t;

    localparam bcd_t SEG_T_MAX   = 4'd5;
    localparam bcd_t HR_T_MAX    = 4'd2;
    localparam bcd_t HR_U_MAX_24 = 4'd3;
    localparam bcd_t BCD_U_MAX   = 4'd9;

    localparam bcd2_t HR_RST_24 = '{t: 4'd0, u: 4'd0};
    localparam bcd2_t HR_RST_12 = '{t: 4'd1, u: 4'd2};
    localparam bcd2_t HR12_PRE  = '{t: 4'd1, u: 4'd1};
    localparam bcd2_t HR12_MIN  = '{t: 4'd0, u: 4'd1};

    function automatic bcd2_t bcd2_inc(bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.u == BCD_U_MAX) begin
            r.u = '0;
            r.t = v.t + 4'd1;
        end else begin
            r.u = v.u + 4'd1;
        end
        return r;
    endfunction

    function automatic logic is_59(bcd2_t v);
        return (v.t == SEG_T_MAX) && (v.u == BCD_U_MAX);
    endfunction

    function automatic bcd2_t inc_mod60(bcd2_t v);
        return is_59(v) ? '0 : bcd2_inc(v);
    endfunction

    function automatic bcd2_t inc_hour24(bcd2_t v);
        return ((v.t == HR_T_MAX) && (v.u == HR_U_MAX_24)) ? '0 : bcd2_inc(v);
    endfunction

endpackage

// File: rtl/relogio_bcd_if.sv
// Control inputs and display outputs of relogio_bcd.
// The slave modport is the clock side; master is the controller/display side.
interface relogio_bcd_if;
    import relogio_pkg::*;

    logic run;
    logic set_en;
    logic inc_min;
    logic inc_hour;
    bcd_t sec_u;
    bcd_t sec_t;
    bcd_t min_u;
    bcd_t min_t;
    bcd_t hr_u;
    bcd_t hr_t;
    logic pm;
    logic tick_1hz;
    logic day_wrap;

    modport master (
        output run, set_en, inc_min, inc_hour,
        input  sec_u, sec_t, min_u, min_t, hr_u, hr_t, pm, tick_1hz, day_wrap
    );

    modport slave (
        input  run, set_en, inc_min, inc_hour,
        output sec_u, sec_t, min_u, min_t, hr_u, hr_t, pm, tick_1hz, day_wrap
    );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler counting 0..CLK_HZ-1 while enabled; tick is high in the terminal cycle.
// clr forces the count back to 0 (used while setting the clock).
module divisor_tick #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/relogio_bcd.sv
// BCD time-of-day counter HH:MM:SS with run/hold and manual set mode.
// Define RELOGIO_FORMATO_12H_EN for 12 h format with pm flag (default is 24 h).
module relogio_bcd
    import relogio_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    relogio_bcd_if.slave   bus
);

    bcd2_t sec_q, sec_d, min_q, min_d, hr_q, hr_d, hr_inc;
    logic  pm_q, pm_d, pm_inc, hr_last;
    logic  tick_q, tick_d, wrap_q, wrap_d;
    logic  cnt_en, tc;

    assign cnt_en = bus.run && !bus.set_en;

    divisor_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_divisor_tick (
        .clk  (clk),
        .reset(reset),
        .en   (cnt_en),
        .clr  (bus.set_en),
        .tick (tc)
    );

`ifdef RELOGIO_FORMATO_12H_EN
    localparam bcd2_t HR_RST = HR_RST_12;

    // 12 -> 01 keeps the half-day; 11 -> 12 flips it.
    always_comb begin
        hr_inc = bcd2_inc(hr_q);
        pm_inc = pm_q;
        if (hr_q == HR_RST_12) begin
            hr_inc = HR12_MIN;
        end else if (hr_q == HR12_PRE) begin
            hr_inc = HR_RST_12;
            pm_inc = ~pm_q;
        end
    end

    assign hr_last = (hr_q == HR12_PRE) && pm_q;
`else
    localparam bcd2_t HR_RST = HR_RST_24;

    assign hr_inc  = inc_hour24(hr_q);
    assign pm_inc  = 1'b0;
    assign hr_last = (hr_q.t == HR_T_MAX) && (hr_q.u == HR_U_MAX_24);
`endif

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hr_d   = hr_q;
        pm_d   = pm_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.set_en) begin
            sec_d = '0;
            if (bus.inc_min) begin
                min_d = inc_mod60(min_q);
            end
            if (bus.inc_hour) begin
                hr_d = hr_inc;
                pm_d = pm_inc;
            end
        end else if (tc) begin
            tick_d = 1'b1;
            sec_d  = inc_mod60(sec_q);
            if (is_59(sec_q)) begin
                min_d = inc_mod60(min_q);
                if (is_59(min_q)) begin
                    hr_d   = hr_inc;
                    pm_d   = pm_inc;
                    wrap_d = hr_last;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= HR_RST;
            pm_q   <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            pm_q   <= pm_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.sec_u    = sec_q.u;
    assign bus.sec_t    = sec_q.t;
    assign bus.min_u    = min_q.u;
    assign bus.min_t    = min_q.t;
    assign bus.hr_u     = hr_q.u;
    assign bus.hr_t     = hr_q.t;
    assign bus.pm       = pm_q;
    assign bus.tick_1hz = tick_q;
    assign bus.day_wrap = wrap_q;

endmodule

// File: tb/tb_relogio_bcd.sv
// Scoreboard bench for relogio_bcd (CLK_HZ=4); reference model keeps time as seconds-of-day.
// Honours RELOGIO_FORMATO_12H_EN when mapping the model to expected digits.
module tb_relogio_bcd;

    localparam int unsigned CLK_HZ = 4;

    logic clk = 1'b0;
    logic reset;

    relogio_bcd_if bus ();

    relogio_bcd #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [26:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_cyc  = 0;

    int m_secs = 0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    function automatic logic [26:0] model_out();
        int h, m, s, hd;
        bit p;
        h  = m_secs / 3600;
        m  = (m_secs / 60) % 60;
        s  = m_secs % 60;
`ifdef RELOGIO_FORMATO_12H_EN
        hd = (h % 12 == 0) ? 12 : h % 12;
        p  = (h >= 12);
`else
        hd = h;
        p  = 1'b0;
`endif
        return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                p, m_tick, m_wrap};
    endfunction

    // Apply inputs for one edge, advance the model and queue the expected result.
    task automatic step(input bit r, input bit rn, input bit se, input bit im, input bit ih);
        int h, m;
        reset        = r;
        bus.run      = rn;
        bus.set_en   = se;
        bus.inc_min  = im;
        bus.inc_hour = ih;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (r) begin
            m_secs = 0;
            m_cnt  = 0;
        end else if (se) begin
            m_cnt = 0;
            h = m_secs / 3600;
            m = (m_secs / 60) % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % 24;
            m_secs = h * 3600 + m * 60;
        end else if (rn) begin
            if (m_cnt == CLK_HZ - 1) begin
                m_cnt  = 0;
                m_secs = (m_secs + 1) % 86400;
                m_tick = 1'b1;
                m_wrap = (m_secs == 0);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic set_time(input int h, input int m);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < h; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < m; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Monitor: the DUT presents a fresh output every cycle.
    always begin
        logic [26:0] e, got;
        @(posedge clk);
        #1;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u,
                   bus.pm, bus.tick_1hz, bus.day_wrap};
            n_chk++;
            if (got === e) begin
                n_pass++;
            end else begin
                $display("FAIL cycle %0d: got %h:%h:%h pm=%b tick=%b wrap=%b, required %h:%h:%h pm=%b tick=%b wrap=%b",
                         n_cyc, got[26:19], got[18:11], got[10:3], got[2], got[1], got[0],
                         e[26:19], e[18:11], e[10:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        bit se_mode;
        reset        = 1'b1;
        bus.run      = 1'b0;
        bus.set_en   = 1'b0;
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        @(posedge clk);
        #2;

        // Reset state, then first tick after CLK_HZ enabled cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Midnight / half-day rollovers: 23:59 then 60 s, and 11:59 then 60 s.
        set_time(23, 59);
        repeat (60 * CLK_HZ + 2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_time(11, 59);
        repeat (60 * CLK_HZ + 2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Count to :37, enter set mode, ignored inc_min outside set mode.
        repeat (37 * CLK_HZ + 1) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // 00:59 with both pulses together.
        set_time(0, 59);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Hold after two prescaler cycles, then resume.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized phases seeded near minute/hour boundaries.
        for (int k = 0; k < 4; k++) begin
            set_time($urandom_range(0, 23), $urandom_range(55, 59));
            se_mode = 1'b0;
            repeat (700) begin
                if ($urandom_range(0, 39) == 0) se_mode = ~se_mode;
                step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, se_mode,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
